// File: rtl/fft_pkg.sv
// fft_pkg: types and defaults shared by the FFT pipeline stages.
//   FFT_WIDTH / FFT_NUM : default sample width and lane count
//   state_t             : butterfly output reorder FSM states
//   cvec_t              : one NUM-lane complex sample vector (Re and Im)
package fft_pkg;

  localparam int FFT_WIDTH = 10;
  localparam int FFT_NUM   = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [FFT_NUM-1:0][FFT_WIDTH-1:0] re;
    logic [FFT_NUM-1:0][FFT_WIDTH-1:0] im;
  } cvec_t;

endpackage

// File: rtl/reorder_buf.sv
// reorder_buf: DEPTH x DW register file that holds the difference-path
// results of one frame until they are drained.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// Storage is not reset; contents are only read after being written.
module reorder_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 320
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bfly_out_reorder.sv
// bfly_out_reorder: re-serialises paired butterfly results into one NUM-lane
// stream. Each frame takes HALF (do1, do2) pairs; do1 goes straight out
// (registered) while do2 is stored, then the stored do2 words are drained
// back to back, giving 2*HALF output cycles per frame.
//   clk, rst          : clock, synchronous active-high reset
//   do1_re/do1_im     : sum-path samples, WIDTH x NUM, signed
//   do2_re/do2_im     : difference-path samples, WIDTH x NUM, signed
//   valid_in          : do1/do2 valid this cycle
//   dout_re/dout_im   : serialised output samples
//   valid_out         : dout valid
//   busy              : FSM not idle
//   err_ovf           : sticky, valid_in seen while draining (pair dropped)
// Optional feature: define BFLY_REORDER_FRAME_MARK_EN to add sof/eof outputs
// marking the first and last valid output of each frame.
module bfly_out_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int NUM   = FFT_NUM,
  parameter int HALF  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH*NUM-1:0] do1_re,
  input  logic [WIDTH*NUM-1:0] do1_im,
  input  logic [WIDTH*NUM-1:0] do2_re,
  input  logic [WIDTH*NUM-1:0] do2_im,
  input  logic                 valid_in,
  output logic [WIDTH*NUM-1:0] dout_re,
  output logic [WIDTH*NUM-1:0] dout_im,
  output logic                 valid_out,
  output logic                 busy,
`ifdef BFLY_REORDER_FRAME_MARK_EN
  output logic                 sof,
  output logic                 eof,
`endif
  output logic                 err_ovf
);

  localparam int LW = WIDTH * NUM;
  localparam int DW = 2 * LW;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            we;
  logic [CW-1:0]   waddr;
  logic [DW-1:0]   rdata;

  assign last  = (cnt == CW'(HALF - 1));
  assign we    = valid_in && (state != DRAIN);
  assign waddr = (state == IDLE) ? '0 : cnt;
  assign busy  = (state != IDLE);

  reorder_buf #(
    .DEPTH (HALF),
    .AW    (CW),
    .DW    (DW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({do2_re, do2_im}),
    .raddr (cnt),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dout_re   <= '0;
      dout_im   <= '0;
      valid_out <= 1'b0;
      err_ovf   <= 1'b0;
`ifdef BFLY_REORDER_FRAME_MARK_EN
      sof       <= 1'b0;
      eof       <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
`ifdef BFLY_REORDER_FRAME_MARK_EN
      sof       <= 1'b0;
      eof       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (valid_in) begin
            dout_re   <= do1_re;
            dout_im   <= do1_im;
            valid_out <= 1'b1;
            cnt       <= CW'(1);
            state     <= FILL;
`ifdef BFLY_REORDER_FRAME_MARK_EN
            sof       <= 1'b1;
`endif
          end
        end
        FILL: begin
          if (valid_in) begin
            dout_re   <= do1_re;
            dout_im   <= do1_im;
            valid_out <= 1'b1;
            if (last) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          // Drain never stalls; a pair arriving now is dropped and flagged.
          dout_re   <= rdata[DW-1:LW];
          dout_im   <= rdata[LW-1:0];
          valid_out <= 1'b1;
          if (valid_in) err_ovf <= 1'b1;
          if (last) begin
            cnt   <= '0;
            state <= IDLE;
`ifdef BFLY_REORDER_FRAME_MARK_EN
            eof   <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfly_out_reorder.sv
module tb_bfly_out_reorder;

  localparam int WIDTH = 10;
  localparam int NUM   = 16;
  localparam int HALF  = 16;
  localparam int LW    = WIDTH * NUM;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] do1_re, do1_im, do2_re, do2_im;
  logic          valid_in;
  logic [LW-1:0] dout_re, dout_im;
  logic          valid_out, busy, err_ovf;
`ifdef BFLY_REORDER_FRAME_MARK_EN
  logic          sof, eof;
`endif

  int checks   = 0;
  int failures = 0;

  bfly_out_reorder #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .HALF  (HALF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .do1_re    (do1_re),
    .do1_im    (do1_im),
    .do2_re    (do2_re),
    .do2_im    (do2_im),
    .valid_in  (valid_in),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .valid_out (valid_out),
    .busy      (busy),
`ifdef BFLY_REORDER_FRAME_MARK_EN
    .sof       (sof),
    .eof       (eof),
`endif
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] fill(input int v);
    logic [LW-1:0] r;
    for (int i = 0; i < NUM; i++) r[i*WIDTH +: WIDTH] = WIDTH'(v);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b);
    valid_in = v;
    do1_re = fill(a);
    do1_im = fill(a);
    do2_re = fill(b);
    do2_im = fill(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0);
    step();
    step();
    checks++;
    if (dout_re !== '0 || dout_im !== '0 || valid_out !== 1'b0 || busy !== 1'b0 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset re=%h im=%h valid=%b busy=%b err=%b, required all 0", dout_re, dout_im, valid_out, busy, err_ovf);
    end
`ifdef BFLY_REORDER_FRAME_MARK_EN
    checks++;
    if (sof !== 1'b0 || eof !== 1'b0) begin
      failures++;
      $display("FAIL reset_marks sof=%b eof=%b, required 0 0", sof, eof);
    end
`endif
    rst = 1'b0;
  endtask

  // T1 (and T6 when marks are enabled): one contiguous frame
  task automatic test_single_frame();
    for (int k = 0; k < HALF; k++) begin
      drive(1'b1, k, 100 + k);
      step();
      checks++;
      if (valid_out !== 1'b1 || dout_re !== fill(k) || dout_im !== fill(k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL frame_fill k=%0d valid=%b busy=%b re=%h im=%h, required valid=1 busy=1 data=%h", k, valid_out, busy, dout_re, dout_im, fill(k));
      end
`ifdef BFLY_REORDER_FRAME_MARK_EN
      checks++;
      if (sof !== (k == 0) || eof !== 1'b0) begin
        failures++;
        $display("FAIL frame_fill_marks k=%0d sof=%b eof=%b, required sof=%b eof=0", k, sof, eof, (k == 0));
      end
`endif
    end
    drive(1'b0, 0, 0);
    for (int k = 0; k < HALF; k++) begin
      step();
      checks++;
      if (valid_out !== 1'b1 || dout_re !== fill(100 + k) || dout_im !== fill(100 + k) || busy !== (k != HALF - 1)) begin
        failures++;
        $display("FAIL frame_drain k=%0d valid=%b busy=%b re=%h im=%h, required valid=1 busy=%b data=%h", k, valid_out, busy, dout_re, dout_im, (k != HALF - 1), fill(100 + k));
      end
`ifdef BFLY_REORDER_FRAME_MARK_EN
      checks++;
      if (sof !== 1'b0 || eof !== (k == HALF - 1)) begin
        failures++;
        $display("FAIL frame_drain_marks k=%0d sof=%b eof=%b, required sof=0 eof=%b", k, sof, eof, (k == HALF - 1));
      end
`endif
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || dout_re !== fill(100 + HALF - 1) || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_end valid=%b busy=%b re=%h, required valid=0 busy=0 re=%h", valid_out, busy, dout_re, fill(100 + HALF - 1));
    end
  endtask

  // T2: input gap of 3 cycles after k=5
  task automatic test_gap();
    for (int k = 0; k < HALF; k++) begin
      drive(1'b1, k, 100 + k);
      step();
      checks++;
      if (valid_out !== 1'b1 || dout_re !== fill(k)) begin
        failures++;
        $display("FAIL gap_fill k=%0d valid=%b re=%h, required valid=1 re=%h", k, valid_out, dout_re, fill(k));
      end
      if (k == 5) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 0, 0);
          step();
          checks++;
          if (valid_out !== 1'b0 || dout_re !== fill(5) || busy !== 1'b1) begin
            failures++;
            $display("FAIL gap_hold g=%0d valid=%b busy=%b re=%h, required valid=0 busy=1 re=%h", g, valid_out, busy, dout_re, fill(5));
          end
        end
      end
    end
    drive(1'b0, 0, 0);
    for (int k = 0; k < HALF; k++) begin
      step();
      checks++;
      if (valid_out !== 1'b1 || dout_re !== fill(100 + k) || dout_im !== fill(100 + k)) begin
        failures++;
        $display("FAIL gap_drain k=%0d valid=%b re=%h im=%h, required valid=1 data=%h", k, valid_out, dout_re, dout_im, fill(100 + k));
      end
    end
    step();
  endtask

  // T3: valid_in during drain cycle 4
  task automatic test_overflow();
    for (int k = 0; k < HALF; k++) begin
      drive(1'b1, k, 100 + k);
      step();
    end
    checks++;
    if (err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre err=%b, required 0", err_ovf);
    end
    for (int k = 0; k < HALF; k++) begin
      if (k == 4) drive(1'b1, 77, 177);
      else        drive(1'b0, 0, 0);
      step();
      checks++;
      if (valid_out !== 1'b1 || dout_re !== fill(100 + k) || dout_im !== fill(100 + k)) begin
        failures++;
        $display("FAIL ovf_drain k=%0d valid=%b re=%h im=%h, required valid=1 data=%h", k, valid_out, dout_re, dout_im, fill(100 + k));
      end
      checks++;
      if (err_ovf !== (k >= 4)) begin
        failures++;
        $display("FAIL ovf_flag k=%0d err=%b, required %b", k, err_ovf, (k >= 4));
      end
    end
    drive(1'b0, 0, 0);
    step();
    step();
    checks++;
    if (err_ovf !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky err=%b valid=%b busy=%b, required err=1 valid=0 busy=0", err_ovf, valid_out, busy);
    end
  endtask

  // T4: reset at drain cycle 8, then a clean frame
  task automatic test_reset_mid();
    for (int k = 0; k < HALF; k++) begin
      drive(1'b1, k, 100 + k);
      step();
    end
    drive(1'b0, 0, 0);
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (dout_re !== fill(107) || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre re=%h busy=%b, required re=%h busy=1", dout_re, busy, fill(107));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dout_re !== '0 || dout_im !== '0 || valid_out !== 1'b0 || busy !== 1'b0 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL rstmid re=%h im=%h valid=%b busy=%b err=%b, required all 0", dout_re, dout_im, valid_out, busy, err_ovf);
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle valid=%b busy=%b, required 0 0", valid_out, busy);
    end
    test_single_frame();
  endtask

  // T5: full-scale signed values pass bit-exact
  task automatic test_extremes();
    logic [LW-1:0] a, b;
    for (int i = 0; i < NUM; i++) begin
      a[i*WIDTH +: WIDTH] = (i % 2 == 0) ? 10'h200 : 10'h1FF;
      b[i*WIDTH +: WIDTH] = (i % 2 == 0) ? 10'h1FF : 10'h200;
    end
    for (int k = 0; k < HALF; k++) begin
      valid_in = 1'b1;
      do1_re = a;
      do1_im = b;
      do2_re = b;
      do2_im = a;
      step();
      checks++;
      if (valid_out !== 1'b1 || dout_re !== a || dout_im !== b) begin
        failures++;
        $display("FAIL ext_fill k=%0d re=%h im=%h, required re=%h im=%h", k, dout_re, dout_im, a, b);
      end
    end
    checks++;
    if ($signed(dout_re[WIDTH-1:0]) !== -10'sd512 || $signed(dout_re[2*WIDTH-1:WIDTH]) !== 10'sd511) begin
      failures++;
      $display("FAIL ext_sign lane0=%0d lane1=%0d, required -512 511", $signed(dout_re[WIDTH-1:0]), $signed(dout_re[2*WIDTH-1:WIDTH]));
    end
    drive(1'b0, 0, 0);
    for (int k = 0; k < HALF; k++) begin
      step();
      checks++;
      if (valid_out !== 1'b1 || dout_re !== b || dout_im !== a) begin
        failures++;
        $display("FAIL ext_drain k=%0d re=%h im=%h, required re=%h im=%h", k, dout_re, dout_im, b, a);
      end
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0);
    test_reset();
    test_single_frame();
    test_gap();
    test_overflow();
    test_reset_mid();
    test_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
